// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_port
// Brief    : Eight-entry register file write port. Each accepted write commits
//            one cycle later. A clear request sweeps every register to zero,
//            one register per cycle. Optional macro REGFILE_R0_ZERO_EN
//            hardwires R0 to zero.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_port #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [7:0]        wr_count
);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit c_r0_zero = 1'b1;
`else
    localparam bit c_r0_zero = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_hold_addr;
    logic [DATA_W-1:0]   r_hold_data;
    logic [2:0]          r_idx;
    logic [7:0]          r_wr_count;
    logic                w_accept;
    logic                w_clr_start;
    logic                w_commit;
    logic                w_sweep;
    logic [DATA_W-1:0]   w_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clr_req wins over a simultaneous write; the write stays pending upstream
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clr_start = 1'b0;
        w_commit    = 1'b0;
        w_sweep     = 1'b0;
        wr_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                wr_ready = 1'b1;
                busy     = 1'b0;
                if (clr_req) begin
                    w_clr_start = 1'b1;
                    w_state_nxt = S_CLEAR;
                end else if (wr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                w_sweep = 1'b1;
                if (r_idx == 3'd7) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_addr <= 3'd0;
            r_hold_data <= '0;
        end else if (w_accept) begin
            r_hold_addr <= wr_addr;
            r_hold_data <= wr_data;
        end
    end

    // Sweep index wraps 7 -> 0 naturally on the final clear cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 3'd0;
        end else if (w_clr_start) begin
            r_idx <= 3'd0;
        end else if (w_sweep) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= 8'd0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        localparam logic [2:0] c_idx = 3'(i);
        if (c_r0_zero && (i == 0)) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_ff
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_commit && (r_hold_addr == c_idx)) begin
                    r_q <= r_hold_data;
                end else if (w_sweep && (r_idx == c_idx)) begin
                    r_q <= '0;
                end
            end
            assign w_regs[i] = r_q;
        end
    end

    assign r0       = w_regs[0];
    assign r1       = w_regs[1];
    assign r2       = w_regs[2];
    assign r3       = w_regs[3];
    assign r4       = w_regs[4];
    assign r5       = w_regs[5];
    assign r6       = w_regs[6];
    assign r7       = w_regs[7];
    assign wr_count = r_wr_count;

`ifndef SYNTHESIS
    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n) wr_ready != busy);
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_IDLE) || (r_state == S_COMMIT) || (r_state == S_CLEAR));
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_port
// Brief    : Directed plus randomized bench for regfile_write_port, checked
//            every cycle against a transaction-level model of the write port.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_port;
    localparam int DATA_W = 16;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [2:0]        wr_addr = 3'd0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr_req = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]        wr_count;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] pat [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011,
                             16'h0100, 16'h0101, 16'h0110, 16'h0111};

    regfile_write_port #(.DATA_W(DATA_W), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy),
        .r0(q0), .r1(q1), .r2(q2), .r3(q3),
        .r4(q4), .r5(q5), .r6(q6), .r7(q7),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_r(input int i);
        case (i)
            0: return q0;
            1: return q1;
            2: return q2;
            3: return q3;
            4: return q4;
            5: return q5;
            6: return q6;
            default: return q7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: a pending write or a count of remaining clear cycles
    logic [15:0] m_regs [8];
    int          m_count;
    bit          m_pend;
    int          m_addr;
    logic [15:0] m_data;
    int          m_clr_left;

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_count = 0; m_pend = 0; m_addr = 0; m_data = '0; m_clr_left = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) m_regs[i] = '0;
                m_count = 0; m_pend = 0; m_addr = 0; m_data = '0; m_clr_left = 0;
            end else if (m_pend) begin
                if (!(R0Z && m_addr == 0)) m_regs[m_addr] = m_data;
                m_count = (m_count + 1) % 256;
                m_pend = 0;
            end else if (m_clr_left > 0) begin
                m_regs[8 - m_clr_left] = '0;
                m_clr_left = m_clr_left - 1;
            end else if (clr_req) begin
                m_clr_left = 8;
            end else if (wr_valid) begin
                m_pend = 1;
                m_addr = int'(wr_addr);
                m_data = wr_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ready", {31'd0, wr_ready}, {31'd0, !m_pend && m_clr_left == 0});
            chk("busy", {31'd0, busy}, {31'd0, m_pend || m_clr_left != 0});
            chk("count", {24'd0, wr_count}, m_count);
            for (int i = 0; i < 8; i++)
                chk($sformatf("r%0d", i), {16'd0, get_r(i)}, {16'd0, m_regs[i]});
        end
    end

    // Present a write, wait for the accepting edge, then drop the request
    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        int  waited = 0;
        logic rdy;
        @(negedge clk); #1;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        forever begin
            rdy = wr_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                chk("write_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk); #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {24'd0, wr_count}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), pat[i]);
            chk("lat_old", {16'd0, get_r(i)}, 32'd0);
            @(posedge clk); #1;
            chk("lat_new", {16'd0, get_r(i)}, (R0Z && i == 0) ? 32'd0 : {16'd0, pat[i]});
        end
        @(negedge clk);
        chk("seq_count", {24'd0, wr_count}, 32'd8);
        chk("seq_r0", {16'd0, q0}, 32'h0000);
        chk("seq_r3", {16'd0, q3}, 32'h0011);
        chk("seq_r5", {16'd0, q5}, 32'h0101);
        chk("seq_r7", {16'd0, q7}, 32'h0111);

        #1;
        base = int'(wr_count);
        wr_valid = 1'b1; wr_addr = 3'($urandom); wr_data = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            chk("hold_ready", {31'd0, wr_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); @(negedge clk); #1;
            wr_addr = 3'($urandom); wr_data = 16'($urandom);
        end
        wr_valid = 1'b0;
        chk("hold_count", {24'd0, wr_count}, 32'((base + 4) % 256));

        base = int'(wr_count);
        clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        @(posedge clk);
        @(negedge clk); #1;
        clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("clr_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); @(negedge clk); #1;
        end
        chk("clr_done_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) chk("clr_zero", {16'd0, get_r(i)}, 32'd0);
        chk("clr_count", {24'd0, wr_count}, base);
        @(posedge clk);
        @(negedge clk); #1;
        wr_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_then_w", {16'd0, q3}, 32'hBEEF);

        do_write(3'd5, 16'h1234);
        @(posedge clk); @(negedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        clr_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, wr_ready}, 32'd1);
        chk("arst_count", {24'd0, wr_count}, 32'd0);
        chk("arst_r3", {16'd0, q3}, 32'd0);
        chk("arst_r5", {16'd0, q5}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 255; n++) do_write(3'($urandom), 16'($urandom));
        @(posedge clk); #1;
        chk("wrap_255", {24'd0, wr_count}, 32'd255);
        do_write(3'($urandom), 16'($urandom));
        @(posedge clk); #1;
        chk("wrap_0", {24'd0, wr_count}, 32'd0);

        do_write(3'd0, 16'hFFFF);
        @(posedge clk); #1;
        chk("r0_write", {16'd0, q0}, R0Z ? 32'd0 : 32'hFFFF);
        chk("r0_count", {24'd0, wr_count}, 32'd1);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            wr_valid = 1'($urandom_range(0, 1));
            clr_req  = ($urandom_range(0, 15) == 0);
            wr_addr  = 3'($urandom);
            wr_data  = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk); #1;
        wr_valid = 1'b0; clr_req = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
